decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter AW, default 3: address width; the block SHALL decode to NY = 2**AW outputs (AW range 1..6).
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per scan step; SHALL be at least 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 G  input  1  active-high enable.
REQ-006 GA  input  1  active-low enable.
REQ-007 GB  input  1  active-low enable.
REQ-008 SCAN  input  1  mode select: 0 is manual decode, 1 is auto-scan.
REQ-009 A  input  AW  manual address; also the scan start address.
REQ-010 Y  output  NY  registered one-hot-low decode; bit i is 0 only when channel i is selected.
REQ-011 CUR  output  AW  address currently driven on Y.
REQ-012 STEP  output  1  one-cycle pulse on the cycle the scan address advances.

Function
REQ-013 The enable term en SHALL be G AND NOT GA AND NOT GB.
REQ-014 The FSM SHALL have three states:
- IDLE: en=0.
- MANUAL: en=1 and SCAN=0.
- SCAN: en=1 and SCAN=1.
- The next state SHALL be re-evaluated every cycle from en and SCAN.
REQ-015 In IDLE, Y SHALL be all ones one cycle later; CUR, the prescaler and STEP SHALL hold/clear as follows: CUR holds, prescaler holds, STEP=0.
REQ-016 In MANUAL, Y SHALL equal NOT(1<<A) and CUR SHALL equal A, both with exactly one cycle latency from the inputs; STEP=0; prescaler=0.
REQ-017 Entering SCAN from MANUAL or IDLE SHALL load CUR with A and clear the prescaler; Y SHALL show NOT(1<<A) on the following cycle.
REQ-018 In SCAN, the prescaler SHALL count 0..SCAN_DIV-1. On the cycle it reaches SCAN_DIV-1:
- it SHALL wrap to 0;
- CUR SHALL advance to the next address;
- STEP SHALL pulse high for that one cycle;
- Y SHALL reflect the new CUR on the same edge.
REQ-019 Scan wrap-around: CUR = NY-1 SHALL advance to 0.
REQ-020 With SCAN_DIV=1, CUR SHALL advance every cycle in SCAN, and STEP SHALL be high continuously.
REQ-021 Dropping en mid-scan SHALL go to IDLE with Y all ones. Re-entry into SCAN restarts from A per REQ-017; no hidden resume.
REQ-022 Changes on A during SCAN SHALL be ignored.
REQ-023 Y SHALL never have more than one zero bit in any cycle.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set:
- Y all ones, CUR=0, STEP=0, prescaler=0;
- state IDLE.
Reset SHALL override all inputs, including mid-scan.
REQ-025 The first decode after rst falls SHALL appear one cycle after the first edge with rst=0.

Configuration
REQ-026 Macro DECODER_SCAN_MASK_EN SHALL add input MASK[NY-1:0]; 1 means the channel is included in the scan.
REQ-027 With DECODER_SCAN_MASK_EN defined, each scan step SHALL move CUR to the next higher address (with wrap) whose MASK bit is 1:
- If only the current channel is set, CUR SHALL hold and STEP still pulses.
- If MASK is all zero in SCAN, Y SHALL be all ones, CUR SHALL hold and STEP SHALL be 0.
- MASK SHALL NOT affect MANUAL mode.
REQ-028 Without the macro, the MASK port SHALL NOT exist and scan SHALL visit every address.

Structure
REQ-029 Package decoder_pkg SHALL hold:
- the FSM state type (IDLE, MANUAL, SCAN);
- the default AW and SCAN_DIV constants.
REQ-030 The prescaler SHALL be a sub-module scan_timer (inputs clk, rst, clr, run; output tick; parameter DIV).
REQ-031 Target size is 120-400 lines of RTL, all outputs registered.

Verification
REQ-032 Enables:
- G=0 -> Y=8'hFF.
- G=1,GA=1 -> Y=8'hFF.
- G=1,GB=1 -> Y=8'hFF.
REQ-033 Manual decode: G=1,GA=0,GB=0,SCAN=0, A stepped 0..7 -> Y=FE,FD,FB,F7,EF,DF,BF,7F, each one cycle after A changes.
REQ-034 Scan: A=6, SCAN raised, SCAN_DIV=4 -> CUR sequence 6,7,0,1; each value held 4 cycles; STEP pulses at each change; Y tracks CUR.
REQ-035 Interruptions:
- Mid-scan rst=1 for 1 cycle -> next edge Y=FF, CUR=0, STEP=0.
- Mid-scan G=0 -> Y=FF next cycle; re-enable restarts at A.
REQ-036 Mask (macro defined): MASK=8'b0010_0100, A=2 -> CUR 2,5,2,5.
REQ-037 All-zero mask (macro defined): MASK=0 -> Y=FF, STEP=0.
REQ-038 Parameter sweep: AW=4, SCAN_DIV=1 -> CUR wraps 15->0, STEP continuously high.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and defaults for the scanning address decoder.
// Holds the FSM state encoding and default width/prescale constants.
// Imported by decoder_scan and anything that needs to reason about its state.
package decoder_pkg;

    localparam int DEF_AW       = 3;
    localparam int DEF_SCAN_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_timer.sv
// Scan prescaler: counts 0..DIV-1 while run is high, raises tick on the last count.
// Latency: tick is combinational from the registered count (same cycle as count==DIV-1).
// Backpressure: none; clr wins over run, and the count holds when neither is asserted.
module scan_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    // Count while running, wrap on the tick cycle, clear on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : (r_cnt + CW'(1));
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Enabled one-hot-low decoder with manual and auto-scan modes; optional MASK via DECODER_SCAN_MASK_EN.
// Latency: Y, CUR and STEP are registered, one cycle from the inputs that select them.
// Backpressure: none; the mode is re-evaluated every cycle and A is ignored while scanning.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  G,
    input  logic                  GA,
    input  logic                  GB,
    input  logic                  SCAN,
    input  logic [AW-1:0]         A,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [(1<<AW)-1:0]    MASK,
`endif
    output logic [(1<<AW)-1:0]    Y,
    output logic [AW-1:0]         CUR,
    output logic                  STEP
);

    localparam int NY = 1 << AW;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_en;
    logic            w_tick;
    logic            w_tmr_clr;
    logic            w_tmr_run;
    logic            w_mask_any;
    logic [AW-1:0]   w_scan_nxt;
    logic [NY-1:0]   w_y_nxt;
    logic [AW-1:0]   w_cur_nxt;
    logic            w_step_nxt;
    logic [NY-1:0]   r_y;
    logic [AW-1:0]   r_cur;
    logic            r_step;

    function automatic logic [NY-1:0] dec_low(input logic [AW-1:0] addr);
        dec_low = ~(NY'(1) << addr);
    endfunction

    assign w_en = G & ~GA & ~GB;

    scan_timer #(
        .DIV (SCAN_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tmr_clr),
        .run  (w_tmr_run),
        .tick (w_tick)
    );

`ifdef DECODER_SCAN_MASK_EN
    logic [AW-1:0] w_idx;
    logic          w_found;

    // Next included channel above CUR (with wrap); k==NY lands back on CUR itself.
    always_comb begin
        w_scan_nxt = r_cur;
        w_mask_any = |MASK;
        w_idx      = r_cur;
        w_found    = 1'b0;
        for (int k = 1; k <= NY; k++) begin
            w_idx = r_cur + AW'(k);
            if (!w_found && MASK[w_idx]) begin
                w_scan_nxt = w_idx;
                w_found    = 1'b1;
            end
        end
    end
`else
    // Without a mask every address is visited; wrap is the natural AW-bit overflow.
    always_comb begin
        w_scan_nxt = r_cur + AW'(1);
        w_mask_any = 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state from en/SCAN, plus the next values of the registered outputs.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_y_nxt     = '1;
        w_cur_nxt   = r_cur;
        w_step_nxt  = 1'b0;
        w_tmr_clr   = 1'b0;
        w_tmr_run   = 1'b0;
        if (w_en) begin
            w_state_nxt = SCAN ? ST_SCAN : ST_MANUAL;
        end
        case (w_state_nxt)
            ST_MANUAL: begin
                w_y_nxt   = dec_low(A);
                w_cur_nxt = A;
                w_tmr_clr = 1'b1;
            end
            ST_SCAN: begin
                if (r_state != ST_SCAN) begin
                    // Fresh entry always restarts from A; nothing is resumed.
                    w_cur_nxt = A;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_tmr_run = 1'b1;
                    if (w_tick && w_mask_any) begin
                        w_cur_nxt  = w_scan_nxt;
                        w_step_nxt = 1'b1;
                    end
                end
                w_y_nxt = w_mask_any ? dec_low(w_cur_nxt) : '1;
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= '1;
            r_cur  <= '0;
            r_step <= 1'b0;
        end else begin
            r_y    <= w_y_nxt;
            r_cur  <= w_cur_nxt;
            r_step <= w_step_nxt;
        end
    end

    assign Y    = r_y;
    assign CUR  = r_cur;
    assign STEP = r_step;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: default instance (AW=3, SCAN_DIV=4) and a second one (AW=4, SCAN_DIV=1).
// Stimulus pushes hand-computed expectations tagged with the edge they belong to;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_decoder_scan;

    logic        clk;
    logic        rst;
    logic        g, ga, gb;
    logic        scan, scan2;
    logic [2:0]  a;
    logic [3:0]  a2;
    logic [7:0]  y;
    logic [2:0]  cur;
    logic        step;
    logic [15:0] y2;
    logic [3:0]  cur2;
    logic        step2;
`ifdef DECODER_SCAN_MASK_EN
    logic [7:0]  mask;
    logic [15:0] mask2;
`endif

    decoder_scan #(.AW(3), .SCAN_DIV(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .G    (g),
        .GA   (ga),
        .GB   (gb),
        .SCAN (scan),
        .A    (a),
`ifdef DECODER_SCAN_MASK_EN
        .MASK (mask),
`endif
        .Y    (y),
        .CUR  (cur),
        .STEP (step)
    );

    decoder_scan #(.AW(4), .SCAN_DIV(1)) u_dut2 (
        .clk  (clk),
        .rst  (rst),
        .G    (g),
        .GA   (ga),
        .GB   (gb),
        .SCAN (scan2),
        .A    (a2),
`ifdef DECODER_SCAN_MASK_EN
        .MASK (mask2),
`endif
        .Y    (y2),
        .CUR  (cur2),
        .STEP (step2)
    );

    typedef struct packed {
        int          cyc;
        logic [1:0]  dut;
        logic [15:0] y;
        logic [3:0]  cur;
        logic        step;
        logic        ccur;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];
    int    edge_cnt = 0;
    int    n_vec    = 0;
    int    n_bad    = 0;

    // One-hot-low patterns for AW=3, written out by hand.
    logic [7:0] man_y [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic exp1(input string nm, input logic [7:0] ey, input logic [2:0] ecur,
                        input logic estep, input logic eccur);
        exp_t e;
        e.cyc = edge_cnt + 1; e.dut = 2'd1; e.y = {8'h00, ey};
        e.cur = {1'b0, ecur}; e.step = estep; e.ccur = eccur;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    task automatic exp2(input string nm, input logic [15:0] ey, input logic [3:0] ecur,
                        input logic estep);
        exp_t e;
        e.cyc = edge_cnt + 1; e.dut = 2'd2; e.y = ey;
        e.cur = ecur; e.step = estep; e.ccur = 1'b1;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    task automatic drive(input logic ig, input logic iga, input logic igb,
                         input logic iscan, input logic [2:0] ia);
        g = ig; ga = iga; gb = igb; scan = iscan; a = ia;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every entry due at this edge.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            n_vec++;
            if (e.cyc != edge_cnt) begin
                n_bad++;
                $display("FAIL %s: entry for edge %0d checked at edge %0d", nm, e.cyc, edge_cnt);
            end else if (e.dut == 2'd1) begin
                if (y !== e.y[7:0] || step !== e.step || (e.ccur && cur !== e.cur[2:0])) begin
                    n_bad++;
                    $display("FAIL %s: got Y=%h CUR=%0d STEP=%b, want Y=%h CUR=%0d STEP=%b",
                             nm, y, cur, step, e.y[7:0], e.cur[2:0], e.step);
                end
            end else begin
                if (y2 !== e.y || step2 !== e.step || (e.ccur && cur2 !== e.cur)) begin
                    n_bad++;
                    $display("FAIL %s: got Y=%h CUR=%0d STEP=%b, want Y=%h CUR=%0d STEP=%b",
                             nm, y2, cur2, step2, e.y, e.cur, e.step);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] sc_cur [16] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                                    3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [15:0] sc_step = 16'b0001_0001_0001_0000;
        logic [2:0] rs_cur [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic [4:0] rs_step = 5'b10000;
        logic [15:0] s2_y [5] = '{16'hBFFF, 16'h7FFF, 16'hFFFE, 16'hFFFD, 16'hFFFB};
        logic [3:0]  s2_cur [5] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        logic [4:0]  s2_step = 5'b11110;

        rst = 1'b1; scan2 = 1'b0; a2 = 4'd0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
`ifdef DECODER_SCAN_MASK_EN
        mask = 8'hFF; mask2 = 16'hFFFF;
`endif
        exp1("reset", 8'hFF, 3'd0, 1'b0, 1'b1);
        exp2("reset2", 16'hFFFF, 4'd0, 1'b0);
        adv();

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
        exp1("en_g0", 8'hFF, 3'd0, 1'b0, 1'b1);
        adv();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
        exp1("en_ga1", 8'hFF, 3'd0, 1'b0, 1'b1);
        adv();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        exp1("en_gb1", 8'hFF, 3'd0, 1'b0, 1'b1);
        adv();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'(i));
            exp1("manual", man_y[i], 3'(i), 1'b0, 1'b1);
            adv();
        end

        // Scan from A=6; A changes after entry and must be ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
        exp1("scan_entry", 8'hBF, 3'd6, 1'b0, 1'b1);
        adv();
        a = 3'd3;
        for (int i = 1; i < 16; i++) begin
            exp1("scan_seq", man_y[sc_cur[i]], sc_cur[i], sc_step[i], 1'b1);
            adv();
        end

        rst = 1'b1;
        exp1("rst_mid", 8'hFF, 3'd0, 1'b0, 1'b1);
        exp2("rst_mid2", 16'hFFFF, 4'd0, 1'b0);
        adv();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp1("scan_after_rst", man_y[rs_cur[i]], rs_cur[i], rs_step[i], 1'b1);
            adv();
        end

        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        exp1("g_drop", 8'hFF, 3'd4, 1'b0, 1'b1);
        adv();
        exp1("g_drop_hold", 8'hFF, 3'd4, 1'b0, 1'b1);
        adv();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        exp1("reenable", 8'hDF, 3'd5, 1'b0, 1'b1);
        adv();
        exp1("reenable_hold", 8'hDF, 3'd5, 1'b0, 1'b1);
        adv();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
        exp1("ga_drop", 8'hFF, 3'd5, 1'b0, 1'b1);
        adv();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        exp1("back_manual", 8'hFB, 3'd2, 1'b0, 1'b1);
        adv();

        // Second instance: AW=4, SCAN_DIV=1 scanning through the 15->0 wrap.
        a2 = 4'd14; scan2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp2("scan_div1", s2_y[i], s2_cur[i], s2_step[i]);
            adv();
            a2 = 4'd9;
        end

`ifdef DECODER_SCAN_MASK_EN
        begin
            logic [2:0]  mk_cur [12] = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5,
                                         3'd2, 3'd2, 3'd2, 3'd2, 3'd5};
            logic [11:0] mk_step = 12'b1000_1000_1000;
            mask = 8'b0010_0100;
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
            exp1("mask_entry", 8'hFB, 3'd2, 1'b0, 1'b1);
            adv();
            for (int i = 0; i < 12; i++) begin
                exp1("mask_seq", man_y[mk_cur[i]], mk_cur[i], mk_step[i], 1'b1);
                adv();
            end
            mask = 8'h00;
            for (int i = 0; i < 5; i++) begin
                exp1("mask_zero", 8'hFF, 3'd5, 1'b0, 1'b1);
                adv();
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
            exp1("mask_manual", 8'hF7, 3'd3, 1'b0, 1'b1);
            adv();
        end
`endif

        adv();
        adv();
        adv();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
